// File: rtl/imm_frame_scheduler_if.sv
// BRAM read port and IMM pixel handshake between the frame scheduler and its neighbours.
// The scheduler is the master: it drives addresses, read enable and pixel strobe, and
// receives the BRAM read data and the IMM ready.
interface imm_frame_scheduler_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 8,
  parameter int PIX_W = 12
) ();
  logic [ROW_W-1:0] row_sel;
  logic [COL_W-1:0] col_sel;
  logic             rd_en;
  logic [PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0] pixel_out;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;
  logic             strobe;
  logic             ready;

  modport master (
    output row_sel, col_sel, rd_en, pixel_out, pix_row, pix_col, strobe,
    input  pixel_in, ready
  );

  modport slave (
    input  row_sel, col_sel, rd_en, pixel_out, pix_row, pix_col, strobe,
    output pixel_in, ready
  );
endinterface

// File: rtl/imm_frame_scheduler.sv
// Raster-scan frame transfer from the image BRAM into the image masking module.
// Each pixel takes ADDR (issue read) -> DATA (BRAM latency) -> HOLD (wait for ready),
// so an unthrottled frame moves one pixel every three cycles. All outputs are registered
// and change on the same edge as the state transition that defines them.
module imm_frame_scheduler #(
  parameter int ROW_W  = 9,
  parameter int COL_W  = 8,
  parameter int PIX_W  = 12,
  parameter int FCNT_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ROW_W-1:0]      cfg_rows,
  input  logic [COL_W-1:0]      cfg_cols,
  imm_frame_scheduler_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [FCNT_W-1:0]     frame_count
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt, last_row;
  logic [COL_W-1:0] col, col_nxt, last_col;
  logic             last_col_hit, last_pix;
  logic             rd_en_nxt, strobe_nxt, done_nxt, busy_nxt;
  logic             capture, launch;

  // The frame geometry is frozen at start, so mid-frame cfg changes cannot disturb the scan.
  assign last_col_hit = (col == last_col);
  assign last_pix     = last_col_hit && (row == last_row);

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition out of a non-idle state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = ADDR;
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = HOLD;
      HOLD:    if (bus.ready) state_nxt = last_pix ? DONE : ADDR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // Next values for the scan counters and the registered outputs, derived from the transition
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (state == IDLE) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if ((state == HOLD) && bus.ready && !last_pix) begin
      if (last_col_hit) begin
        row_nxt = row + ROW_W'(1);
        col_nxt = '0;
      end else begin
        col_nxt = col + COL_W'(1);
      end
    end
    rd_en_nxt  = (state_nxt == ADDR);
    strobe_nxt = (state_nxt == HOLD);
    done_nxt   = (state_nxt == DONE);
    busy_nxt   = (state_nxt != IDLE);
    capture    = (state == DATA) && (state_nxt == HOLD);
    launch     = (state == IDLE) && (state_nxt == ADDR);
  end

  // Output and datapath registers; read data is captured on the edge leaving DATA
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      row           <= '0;
      col           <= '0;
      last_row      <= '0;
      last_col      <= '0;
      bus.row_sel   <= '0;
      bus.col_sel   <= '0;
      bus.rd_en     <= 1'b0;
      bus.pixel_out <= '0;
      bus.pix_row   <= '0;
      bus.pix_col   <= '0;
      bus.strobe    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_count   <= '0;
    end else begin
      row        <= row_nxt;
      col        <= col_nxt;
      bus.rd_en  <= rd_en_nxt;
      bus.strobe <= strobe_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      if (launch) begin
        last_row <= cfg_rows;
        last_col <= cfg_cols;
      end
      if (rd_en_nxt) begin
        bus.row_sel <= row_nxt;
        bus.col_sel <= col_nxt;
      end
      if (capture) begin
        bus.pixel_out <= bus.pixel_in;
        bus.pix_row   <= row;
        bus.pix_col   <= col;
      end
      if (done_nxt) frame_count <= frame_count + FCNT_W'(1);
    end
  end

endmodule
